// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolution controller: RV32I branch
// funct3 encodings, FSM state type, sequential PC step, and the funct3 to
// flag-mux select mapping.
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned PC_STEP = 4;

  // Mux select value that picks no flag (used for illegal encodings).
  localparam logic [2:0] SEL_NONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Map a branch funct3 onto the flag vector order {GEU,LTU,GE,LT,NE,EQ}.
  function automatic logic [2:0] f3_to_sel(input logic [2:0] f3);
    logic [2:0] sel;
    sel = SEL_NONE;
    case (f3)
      F3_BEQ:  sel = 3'd0;
      F3_BNE:  sel = 3'd1;
      F3_BLT:  sel = 3'd2;
      F3_BGE:  sel = 3'd3;
      F3_BLTU: sel = 3'd4;
      F3_BGEU: sel = 3'd5;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return f3_to_sel(f3) == SEL_NONE;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Request/response bus between the execute stage, fetch and the branch
// resolution controller.
//   request : req_valid/req_ready, funct3, rs1, rs2, pc, imm, pred_taken, flush
//   response: resp_valid/resp_ready, taken, redirect, target, illegal
//   stats   : br_count, mispred_count
interface branch_resolve_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic             taken;
  logic             redirect;
  logic [XLEN-1:0]  target;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  modport slave (
    input  req_valid, funct3, rs1, rs2, pc, imm, pred_taken, flush, resp_ready,
    output req_ready, resp_valid, taken, redirect, target, illegal,
           br_count, mispred_count
  );

  modport master (
    output req_valid, funct3, rs1, rs2, pc, imm, pred_taken, flush, resp_ready,
    input  req_ready, resp_valid, taken, redirect, target, illegal,
           br_count, mispred_count
  );
endinterface

// File: rtl/branch_flag_gen.sv
// Full-width comparator producing the six branch condition flags.
// Ports: a, b (operands), flags_c = {GEU, LTU, GE, LT, NE, EQ}.
module branch_flag_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [5:0]      flags_c
);
  logic eq_c;
  logic lt_c;
  logic ltu_c;

  assign eq_c  = (a == b);
  assign lt_c  = ($signed(a) < $signed(b));
  assign ltu_c = (a < b);

  assign flags_c = {~ltu_c, ltu_c, ~lt_c, lt_c, ~eq_c, eq_c};
endmodule

// File: rtl/mux6x1_1b.sv
// Six-input single-bit mux. Ports: d (6 data bits), sel (0..5 picks d[sel],
// anything else yields 0), y_c (combinational result).
module mux6x1_1b (
  input  logic [5:0] d,
  input  logic [2:0] sel,
  output logic       y_c
);
  always_comb begin
    y_c = 1'b0;
    case (sel)
      3'd0:    y_c = d[0];
      3'd1:    y_c = d[1];
      3'd2:    y_c = d[2];
      3'd3:    y_c = d[3];
      3'd4:    y_c = d[4];
      3'd5:    y_c = d[5];
      default: y_c = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Multicycle branch resolution controller: accepts one branch, compares the
// latched operands, and returns taken/redirect/target to fetch. Keeps
// saturating counts of resolved branches and mispredictions.
// Ports: clk, rst_n (synchronous, active low), bus (slave side of
// branch_resolve_ctrl_if).
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  branch_resolve_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, imm_q;
  logic             pred_q;

  logic             req_ready_q, resp_valid_q;
  logic             taken_q, redirect_q, illegal_q;
  logic [XLEN-1:0]  target_q;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  logic [5:0]       flags_c;
  logic [2:0]       sel_c;
  logic             flag_c;
  logic             illegal_c;
  logic             redirect_c;
  logic [XLEN-1:0]  target_c;
  logic             resp_done_c;
  logic             go_idle_c;

  branch_flag_gen #(.XLEN(XLEN)) u_flag_gen (
    .a       (rs1_q),
    .b       (rs2_q),
    .flags_c (flags_c)
  );

  assign sel_c = f3_to_sel(funct3_q);

  mux6x1_1b u_flag_mux (
    .d   (flags_c),
    .sel (sel_c),
    .y_c (flag_c)
  );

  // Illegal encodings select no flag, so they resolve not-taken to pc+4.
  assign illegal_c  = f3_illegal(funct3_q);
  assign redirect_c = ~illegal_c & (flag_c ^ pred_q);
  assign target_c   = flag_c ? (pc_q + imm_q) : (pc_q + XLEN'(PC_STEP));

  // Flush beats a same-cycle response handshake.
  assign resp_done_c = (state == RESP) && bus.resp_ready && !bus.flush;
  assign go_idle_c   = ((state != IDLE) && bus.flush) || resp_done_c;

  // Controller FSM, operand latch, response registers and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      funct3_q     <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      pred_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      redirect_q   <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      br_cnt_q     <= '0;
      mis_cnt_q    <= '0;
    end else if (go_idle_c) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      redirect_q   <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      if (resp_done_c) begin
        if (br_cnt_q != CNT_MAX) br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (redirect_q && (mis_cnt_q != CNT_MAX)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q && !bus.flush) begin
            funct3_q    <= bus.funct3;
            rs1_q       <= bus.rs1;
            rs2_q       <= bus.rs2;
            pc_q        <= bus.pc;
            imm_q       <= bus.imm;
            pred_q      <= bus.pred_taken;
            req_ready_q <= 1'b0;
            state       <= CMP;
          end
        end
        CMP: begin
          taken_q      <= flag_c;
          redirect_q   <= redirect_c;
          illegal_q    <= illegal_c;
          target_q     <= target_c;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          // Hold the response until fetch takes it.
        end
        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.taken         = taken_q;
  assign bus.redirect      = redirect_q;
  assign bus.illegal       = illegal_q;
  assign bus.target        = target_q;
  assign bus.br_count      = br_cnt_q;
  assign bus.mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl. Counters are narrowed to 4 bits so
// saturation is reachable in a short run.
module tb_branch_resolve_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        t;
    logic        r;
    logic        ill;
    logic [31:0] tgt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [CNT_W-1:0] br_m;
  logic [CNT_W-1:0] mis_m;
  vec_t vecs[8];

  branch_resolve_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.funct3     = v.f3;
    bus.rs1        = v.a;
    bus.rs2        = v.b;
    bus.pc         = v.pc;
    bus.imm        = v.imm;
    bus.pred_taken = v.pred;
  endtask

  // One complete branch; stall = cycles resp_ready is held low in RESP.
  task automatic run_branch(input string tag, input vec_t v, input int stall);
    drive_req(v);
    bus.resp_ready = (stall == 0);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk({tag, ".cmp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".cmp_ready"}, 32'(bus.req_ready), 32'd0);
    tick();
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, ".taken"}, 32'(bus.taken), 32'(v.t));
    chk({tag, ".redirect"}, 32'(bus.redirect), 32'(v.r));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(v.ill));
    chk({tag, ".target"}, bus.target, v.tgt);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, ".stall_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, ".stall_taken"}, 32'(bus.taken), 32'(v.t));
      chk({tag, ".stall_target"}, bus.target, v.tgt);
      chk({tag, ".stall_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, ".stall_br"}, 32'(bus.br_count), 32'(br_m));
      chk({tag, ".stall_mis"}, 32'(bus.mispred_count), 32'(mis_m));
    end
    bus.resp_ready = 1'b1;
    tick();
    if (br_m != CMAX) br_m = br_m + 1'b1;
    if (v.r && (mis_m != CMAX)) mis_m = mis_m + 1'b1;
    chk({tag, ".done_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".done_taken"}, 32'(bus.taken), 32'd0);
    chk({tag, ".br_count"}, 32'(bus.br_count), 32'(br_m));
    chk({tag, ".mispred_count"}, 32'(bus.mispred_count), 32'(mis_m));
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    br_m  = '0;
    mis_m = '0;

    //          f3      rs1           rs2           pc            imm           pred t     r     ill   target
    vecs[0] = '{3'b000, 32'd5,        32'd5,        32'h100,      32'h20,       1'b0, 1'b1, 1'b1, 1'b0, 32'h120};
    vecs[1] = '{3'b100, 32'hFFFFFFFF, 32'd1,        32'h200,      32'hFFFFFFF0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1F0};
    vecs[2] = '{3'b110, 32'hFFFFFFFF, 32'd1,        32'h200,      32'hFFFFFFF0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h204};
    vecs[3] = '{3'b001, 32'd7,        32'd7,        32'h300,      32'h40,       1'b0, 1'b0, 1'b0, 1'b0, 32'h304};
    vecs[4] = '{3'b101, 32'hFFFFFFFB, 32'd3,        32'h400,      32'h10,       1'b1, 1'b0, 1'b1, 1'b0, 32'h404};
    vecs[5] = '{3'b111, 32'h80000000, 32'd1,        32'h500,      32'hFFFFFF00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400};
    vecs[6] = '{3'b000, 32'd0,        32'd0,        32'hFFFFFFFC, 32'h8,        1'b1, 1'b1, 1'b0, 1'b0, 32'h4};
    vecs[7] = '{3'b101, 32'd3,        32'd3,        32'h10,       32'h8,        1'b1, 1'b1, 1'b0, 1'b0, 32'h18};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.funct3     = '0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.pc         = '0;
    bus.imm        = '0;
    bus.pred_taken = 1'b0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (3) tick();
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.target", bus.target, 32'd0);
    chk("rst.br_count", 32'(bus.br_count), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_branch($sformatf("vec%0d", i), vecs[i], 0);

    // Response held while fetch stalls.
    v = '{3'b001, 32'd1, 32'd2, 32'h600, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700};
    run_branch("stall", v, 5);

    // Reserved funct3 encodings.
    v = '{3'b010, 32'd5, 32'd5, 32'h700, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h704};
    run_branch("ill010", v, 0);
    v = '{3'b011, 32'd5, 32'd6, 32'h800, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h804};
    run_branch("ill011", v, 0);

    // Flush while comparing.
    v = '{3'b000, 32'd1, 32'd1, 32'h900, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 32'h940};
    drive_req(v);
    bus.resp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_cmp.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("flush_cmp.req_ready", 32'(bus.req_ready), 32'd1);
    chk("flush_cmp.br_count", 32'(bus.br_count), 32'(br_m));
    chk("flush_cmp.mispred", 32'(bus.mispred_count), 32'(mis_m));

    // Flush racing the response handshake.
    drive_req(v);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("flush_resp.pre_valid", 32'(bus.resp_valid), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_resp.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("flush_resp.req_ready", 32'(bus.req_ready), 32'd1);
    chk("flush_resp.br_count", 32'(bus.br_count), 32'(br_m));
    chk("flush_resp.mispred", 32'(bus.mispred_count), 32'(mis_m));

    // Flush in IDLE blocks a same-cycle request.
    drive_req(v);
    bus.flush = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_idle.req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("flush_idle.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("flush_idle.br_count", 32'(bus.br_count), 32'(br_m));

    // Drive both counters into saturation with mispredicting branches.
    v = '{3'b000, 32'd9, 32'd9, 32'hA00, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA10};
    for (int i = 0; i < 12; i++) run_branch($sformatf("sat%0d", i), v, 0);
    chk("sat.br_count", 32'(bus.br_count), 32'hF);
    chk("sat.mispred", 32'(bus.mispred_count), 32'hF);

    // Reset in the middle of a comparison.
    drive_req(v);
    tick();
    bus.req_valid = 1'b0;
    rst_n         = 1'b0;
    tick();
    rst_n = 1'b1;
    br_m  = '0;
    mis_m = '0;
    chk("rst_cmp.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_cmp.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_cmp.taken", 32'(bus.taken), 32'd0);
    chk("rst_cmp.redirect", 32'(bus.redirect), 32'd0);
    chk("rst_cmp.illegal", 32'(bus.illegal), 32'd0);
    chk("rst_cmp.target", bus.target, 32'd0);
    chk("rst_cmp.br_count", 32'(bus.br_count), 32'd0);
    chk("rst_cmp.mispred", 32'(bus.mispred_count), 32'd0);
    tick();
    chk("rst_cmp.idle_valid", 32'(bus.resp_valid), 32'd0);
    run_branch("post_rst", vecs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Multicycle branch-resolution controller for the RV32I execute stage.
- Accepts one conditional branch at a time (funct3, rs1, rs2, pc, imm, predicted direction) over a valid/ready handshake.
- Registers the operands and generates the six comparison flags (EQ, NE, LT, GE, LTU, GEU).
- Selects the flag via funct3 through the existing mux6x1_1b, then delivers a taken/redirect/target response to fetch over a second valid/ready handshake.
- Also keeps saturating statistics counters for branches resolved and mispredictions.

Parameters:
- XLEN, 32, operand/PC width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  branch request valid.
- req_ready  out  1  controller can accept a request.
- funct3  in  3  branch type (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- rs1  in  XLEN  first operand.
- rs2  in  XLEN  second operand.
- pc  in  XLEN  branch PC.
- imm  in  XLEN  sign-extended B-immediate.
- pred_taken  in  1  fetch's predicted direction.
- flush  in  1  kill any in-flight branch (older-instruction trap).
- resp_valid  out  1  response valid.
- resp_ready  in  1  fetch accepts the response.
- taken  out  1  resolved direction.
- redirect  out  1  taken != pred_taken; fetch must restart at target.
- target  out  XLEN  pc+imm if taken, else pc+4.
- illegal  out  1  funct3 is 010 or 011.
- br_count  out  CNT_W  branches resolved (saturating).
- mispred_count  out  CNT_W  redirects issued (saturating).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Both counters cleared.
  - An in-flight request is discarded, and reset overrides flush.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch funct3/rs1/rs2/pc/imm/pred_taken and go to CMP.
- CMP:
  - req_ready=0.
  - Compute the flags from the latched operands. LT/GE are signed, LTU/GEU unsigned, all at full XLEN.
  - Select the flag with mux6x1_1b using the latched funct3.
  - Compute pc+imm and pc+4 modulo 2^XLEN (wrap-around allowed, no overflow flag).
  - Register taken/redirect/target/illegal, then go to RESP.
- RESP:
  - resp_valid=1.
  - Outputs are held stable until resp_ready.
  - On resp_valid&&resp_ready go to IDLE.
  - In that same cycle, br_count+=1 and mispred_count+=redirect. Both saturate at all-ones.
- Latency: response is visible 2 cycles after the accepting edge when resp_ready is held high.
- Throughput: one branch per 3 cycles. No new request is accepted until the cycle after the response handshake (req_ready is low in CMP/RESP).
- Illegal funct3:
  - taken=0, redirect=0, illegal=1, target=pc+4.
  - Counted in br_count, never in mispred_count.
- flush:
  - In CMP or RESP: next state is IDLE, resp_valid drops next cycle, counters unchanged.
  - In IDLE: a same-cycle req_valid is not accepted.
  - Same cycle as a RESP handshake: flush wins, the response is not counted.
- Output registers clear to 0 whenever the FSM enters IDLE.

Decomposition:
- Shared package holds:
  - branch funct3 encodings (F3_BEQ…F3_BGEU);
  - state enum (IDLE/CMP/RESP);
  - constant PC_STEP=4.
- One sub-module, branch_flag_gen: purely combinational XLEN comparator producing the six flags, whose outputs feed mux6x1_1b.
- Counters and FSM live in the top block.

Test Plan:
- BEQ rs1=5 rs2=5 pc=0x100 imm=0x20 pred=0, resp_ready=1 -> resp_valid 2 cycles after accept; taken=1, redirect=1, target=0x120, mispred_count=1.
- BLT rs1=0xFFFFFFFF rs2=1, then BLTU same operands, pred=1 -> first: taken=1, redirect=0; second: taken=0, redirect=1, target=pc+4.
- resp_ready held low 5 cycles in RESP -> resp_valid and outputs stable, req_ready=0, counters unchanged until the handshake.
- funct3=010 -> illegal=1, taken=0, redirect=0, br_count+1, mispred_count unchanged.
- flush asserted in CMP, then separately in RESP concurrent with resp_ready -> IDLE next cycle, no response counted, req_ready=1.
- Preload the counters near 0xFFFF via repeated mispredicting branches -> both saturate at 0xFFFF. rst_n low mid-CMP -> IDLE, all outputs 0, counters 0.
